// File: rtl/collision_probe_sequencer_pkg.sv
// Shared definitions for the collision probe sequencer: FSM states,
// probe ordering and default tile/map geometry.
package collision_probe_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT   = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  // Probe order within a frame; also the bit index into the flag vectors.
  localparam logic [1:0] PROBE_DOWN  = 2'd0;
  localparam logic [1:0] PROBE_UP    = 2'd1;
  localparam logic [1:0] PROBE_LEFT  = 2'd2;
  localparam logic [1:0] PROBE_RIGHT = 2'd3;

  localparam int DEF_TILE_BITS  = 3;
  localparam int DEF_MAP_W_BITS = 5;
  localparam int DEF_MAP_H_BITS = 4;
  localparam int DEF_CHAR_W     = 8;
  localparam int DEF_CHAR_H     = 8;
  localparam int DEF_TIMEOUT    = 15;

  // Signed coordinate width: one bit above the 8-bit screen position.
  localparam int COORD_W = 9;

endpackage

// File: rtl/collision_probe_sequencer_probe_point_gen.sv
// Combinational probe point generator: turns the snapshot sprite position
// and probe index into a tile-map address plus out-of-bounds info.
module probe_point_gen
  import collision_probe_sequencer_pkg::*;
#(
  parameter int TILE_BITS  = DEF_TILE_BITS,
  parameter int MAP_W_BITS = DEF_MAP_W_BITS,
  parameter int MAP_H_BITS = DEF_MAP_H_BITS,
  parameter int CHAR_W     = DEF_CHAR_W,
  parameter int CHAR_H     = DEF_CHAR_H
) (
  input  logic signed [COORD_W-1:0]           x_i,
  input  logic signed [COORD_W-1:0]           y_i,
  input  logic        [1:0]                   idx_i,
  output logic        [MAP_H_BITS+MAP_W_BITS-1:0] addr_o,
  output logic                                oob_o,
  output logic                                oob_flag_o
);

  localparam logic signed [COORD_W-1:0] HALF_W = COORD_W'(CHAR_W / 2);
  localparam logic signed [COORD_W-1:0] HALF_H = COORD_W'(CHAR_H / 2);
  localparam logic signed [COORD_W-1:0] FULL_W = COORD_W'(CHAR_W);
  localparam logic signed [COORD_W-1:0] FULL_H = COORD_W'(CHAR_H);
  localparam logic signed [COORD_W-1:0] ONE    = COORD_W'(1);
  localparam logic        [COORD_W-1:0] COLS   = COORD_W'(1 << MAP_W_BITS);
  localparam logic        [COORD_W-1:0] ROWS   = COORD_W'(1 << MAP_H_BITS);

  logic signed [COORD_W-1:0] px, py;
  logic        [COORD_W-1:0] col, row;

  // Probe point, tile coordinates and bounds check; negative points are
  // caught by the sign bit before the shift so nothing wraps.
  always_comb begin
    px = x_i;
    py = y_i;
    case (idx_i)
      PROBE_DOWN:  begin px = x_i + HALF_W; py = y_i + FULL_H; end
      PROBE_UP:    begin px = x_i + HALF_W; py = y_i - ONE;    end
      PROBE_LEFT:  begin px = x_i - ONE;    py = y_i + HALF_H; end
      default:     begin px = x_i + FULL_W; py = y_i + HALF_H; end
    endcase
    col        = px >> TILE_BITS;
    row        = py >> TILE_BITS;
    oob_o      = px[COORD_W-1] | py[COORD_W-1] | (col >= COLS) | (row >= ROWS);
    addr_o     = {row[MAP_H_BITS-1:0], col[MAP_W_BITS-1:0]};
    // The head may leave the top of the screen; every other edge is solid.
    oob_flag_o = (idx_i != PROBE_UP);
  end

endmodule

// File: rtl/collision_probe_sequencer.sv
// Per-frame collision probe sequencer: four tile-map lookups around the
// sprite, then an atomic commit of the blocked flags with a move_enable pulse.
module collision_probe_sequencer
  import collision_probe_sequencer_pkg::*;
#(
  parameter int TILE_BITS  = DEF_TILE_BITS,
  parameter int MAP_W_BITS = DEF_MAP_W_BITS,
  parameter int MAP_H_BITS = DEF_MAP_H_BITS,
  parameter int CHAR_W     = DEF_CHAR_W,
  parameter int CHAR_H     = DEF_CHAR_H,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                               clock,
  input  logic                               resetn,
  input  logic                               frame_tick,
  input  logic [7:0]                         x_position,
  input  logic [7:0]                         y_position,
  output logic                               mem_req,
  output logic [MAP_H_BITS+MAP_W_BITS-1:0]   mem_addr,
  input  logic                               mem_gnt,
  input  logic                               mem_valid,
  input  logic                               mem_rdata,
  output logic                               left_blocked,
  output logic                               right_blocked,
  output logic                               up_blocked,
  output logic                               down_blocked,
  output logic                               move_enable,
  output logic                               busy,
  output logic                               overrun
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e                    state_q, state_d;
  logic [1:0]                idx_q, idx_d;
  logic signed [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0]          tcnt_q, tcnt_d;
  logic [3:0]                shadow_q, shadow_d;
  logic [3:0]                flags_q, flags_d;
  logic                      move_q, move_d;
  logic                      ovr_q, ovr_d;
  logic                      oob, oob_flag;

  probe_point_gen #(
    .TILE_BITS (TILE_BITS),
    .MAP_W_BITS(MAP_W_BITS),
    .MAP_H_BITS(MAP_H_BITS),
    .CHAR_W    (CHAR_W),
    .CHAR_H    (CHAR_H)
  ) u_ppg (
    .x_i       (x_q),
    .y_i       (y_q),
    .idx_i     (idx_q),
    .addr_o    (mem_addr),
    .oob_o     (oob),
    .oob_flag_o(oob_flag)
  );

  // State register; flags reset to blocked so the sprite is frozen until
  // the first commit.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      tcnt_q   <= '0;
      shadow_q <= '1;
      flags_q  <= '1;
      move_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      x_q      <= x_d;
      y_q      <= y_d;
      tcnt_q   <= tcnt_d;
      shadow_q <= shadow_d;
      flags_q  <= flags_d;
      move_q   <= move_d;
      ovr_q    <= ovr_d;
    end
  end

  // Next-state: sequence the four probes, resolve OOB probes locally,
  // fail safe to blocked on a memory timeout, then commit all flags at once.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    x_d      = x_q;
    y_d      = y_q;
    tcnt_d   = tcnt_q;
    shadow_d = shadow_q;
    flags_d  = flags_q;
    move_d   = 1'b0;
    ovr_d    = frame_tick && (state_q != ST_IDLE);
    mem_req  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_tick) begin
          x_d     = $signed({1'b0, x_position});
          y_d     = $signed({1'b0, y_position});
          idx_d   = PROBE_DOWN;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (oob) begin
          shadow_d[idx_q] = oob_flag;
          state_d = (idx_q == PROBE_RIGHT) ? ST_COMMIT : ST_REQ;
          idx_d   = idx_q + 2'd1;
        end else begin
          mem_req = 1'b1;
          if (mem_gnt) begin
            tcnt_d  = '0;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (mem_valid || tcnt_q == CNT_LAST) begin
          shadow_d[idx_q] = mem_valid ? mem_rdata : 1'b1;
          state_d = (idx_q == PROBE_RIGHT) ? ST_COMMIT : ST_REQ;
          idx_d   = idx_q + 2'd1;
        end else begin
          tcnt_d = tcnt_q + CNT_W'(1);
        end
      end
      default: begin
        flags_d = shadow_q;
        move_d  = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy          = (state_q != ST_IDLE);
  assign move_enable   = move_q;
  assign overrun       = ovr_q;
  assign down_blocked  = flags_q[PROBE_DOWN];
  assign up_blocked    = flags_q[PROBE_UP];
  assign left_blocked  = flags_q[PROBE_LEFT];
  assign right_blocked = flags_q[PROBE_RIGHT];

endmodule

// File: tb/tb_collision_probe_sequencer.sv
// Directed, table-driven bench for collision_probe_sequencer with a small
// tile-map memory model (configurable grant stall and dropped response).
module tb_collision_probe_sequencer;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       frame_tick = 1'b0;
  logic [7:0] x_position = '0, y_position = '0;
  logic       mem_req, mem_gnt;
  logic [8:0] mem_addr;
  logic       mem_valid = 1'b0, mem_rdata = 1'b0;
  logic       left_blocked, right_blocked, up_blocked, down_blocked;
  logic       move_enable, busy, overrun;

  collision_probe_sequencer dut (
    .clock(clock), .resetn(resetn), .frame_tick(frame_tick),
    .x_position(x_position), .y_position(y_position),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .left_blocked(left_blocked), .right_blocked(right_blocked),
    .up_blocked(up_blocked), .down_blocked(down_blocked),
    .move_enable(move_enable), .busy(busy), .overrun(overrun)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // memory model: grant immediately unless stalling on stall_addr,
  // valid on the cycle after the grant unless the address is dropped
  logic       solid_map [0:511];
  int         stall_cnt = 0, stall_lim = 0, nreq = 0;
  logic [8:0] stall_addr = '0, drop_addr = '0;
  logic       drop_en = 1'b0;

  assign mem_gnt = mem_req && !(mem_addr == stall_addr && stall_cnt < stall_lim);

  always @(posedge clock) begin
    mem_valid <= 1'b0;
    if (mem_req && mem_gnt) begin
      nreq <= nreq + 1;
      if (!(drop_en && mem_addr == drop_addr)) begin
        mem_valid <= 1'b1;
        mem_rdata <= solid_map[mem_addr];
      end
    end else if (mem_req) begin
      stall_cnt <= stall_cnt + 1;
    end
  end

  // mem_addr must not move while a request is waiting for its grant
  logic       prev_req = 1'b0, prev_gnt = 1'b0;
  logic [8:0] prev_addr = '0;
  int         addr_bad = 0;
  always @(negedge clock) begin
    if (mem_req && prev_req && !prev_gnt && mem_addr != prev_addr) addr_bad <= addr_bad + 1;
    prev_req  <= mem_req;
    prev_gnt  <= mem_gnt;
    prev_addr <= mem_addr;
  end

  int tests = 0, failed = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {down_blocked, up_blocked, left_blocked, right_blocked};
  endfunction

  typedef struct {
    string      name;
    logic [7:0] x, y;
    int         s0, s1, s2;     // solid tile addresses, -1 = unused
    int         stall_n;        // grant stall cycles on stall_a
    int         stall_a;
    int         drop_a;         // address whose response never comes, -1 = none
    logic [3:0] exp_flags;      // {down, up, left, right}
    int         exp_nreq;
    int         exp_lat;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(string n, logic [7:0] x, logic [7:0] y, int s0, int s1, int s2,
                              int sn, int sa, int da, logic [3:0] ef, int enr, int el);
    vec_t v;
    v.name = n; v.x = x; v.y = y; v.s0 = s0; v.s1 = s1; v.s2 = s2;
    v.stall_n = sn; v.stall_a = sa; v.drop_a = da;
    v.exp_flags = ef; v.exp_nreq = enr; v.exp_lat = el;
    return v;
  endfunction

  int t0;

  task automatic tick();
    @(negedge clock);
    frame_tick = 1'b1;
    @(posedge clock);
    #1;
    t0 = cyc;
    frame_tick = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = mk("open",      8'd72,  8'd40,  -1,  -1,  -1, 0,   0,  -1, 4'b0000, 4,  9);
    vecs[1] = mk("floor",     8'd72,  8'd40,  201, -1,  -1, 0,   0,  -1, 4'b1000, 4,  9);
    vecs[2] = mk("walls",     8'd72,  8'd40,  137, 168, 170, 0,  0,  -1, 4'b0111, 4,  9);
    vecs[3] = mk("top_y0",    8'd72,  8'd0,   -1,  -1,  -1, 0,   0,  -1, 4'b0000, 3,  8);
    vecs[4] = mk("bot_y120",  8'd72,  8'd120, -1,  -1,  -1, 0,   0,  -1, 4'b1000, 3,  8);
    vecs[5] = mk("bot_y124",  8'd72,  8'd124, -1,  -1,  -1, 0,   0,  -1, 4'b1011, 1,  6);
    vecs[6] = mk("left_x0",   8'd0,   8'd40,  -1,  -1,  -1, 0,   0,  -1, 4'b0010, 3,  8);
    vecs[7] = mk("right_x248",8'd248, 8'd40,  -1,  -1,  -1, 0,   0,  -1, 4'b0001, 3,  8);
    vecs[8] = mk("gnt_stall", 8'd72,  8'd40,  -1,  -1,  -1, 5, 168,  -1, 4'b0000, 4, 14);
    vecs[9] = mk("timeout",   8'd72,  8'd40,  -1,  -1,  -1, 0,   0, 170, 4'b0001, 4, 23);

    for (int i = 0; i < 512; i++) solid_map[i] = 1'b0;

    // reset state
    repeat (3) @(negedge clock);
    chk("rst_flags", flags(), 4'b1111);
    chk("rst_move", move_enable, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    resetn = 1'b1;
    repeat (3) @(negedge clock);
    chk("idle_frozen", flags(), 4'b1111);

    for (int v = 0; v < 10; v++) begin
      int lat, reqs0, bad0;
      logic [3:0] pre;
      bit partial;
      for (int i = 0; i < 512; i++) solid_map[i] = 1'b0;
      if (vecs[v].s0 >= 0) solid_map[vecs[v].s0] = 1'b1;
      if (vecs[v].s1 >= 0) solid_map[vecs[v].s1] = 1'b1;
      if (vecs[v].s2 >= 0) solid_map[vecs[v].s2] = 1'b1;
      stall_addr = 9'(vecs[v].stall_a);
      stall_lim  = stall_cnt + vecs[v].stall_n;
      drop_en    = (vecs[v].drop_a >= 0);
      drop_addr  = 9'(vecs[v].drop_a);
      x_position = vecs[v].x;
      y_position = vecs[v].y;
      pre   = flags();
      reqs0 = nreq;
      bad0  = addr_bad;
      partial = 1'b0;
      lat = -1;
      tick();
      for (int k = 0; k < 60; k++) begin
        @(negedge clock);
        if (move_enable) begin
          lat = cyc - t0;
          break;
        end
        if (flags() != pre) partial = 1'b1;
      end
      chk({vecs[v].name, "_latency"}, lat, vecs[v].exp_lat);
      chk({vecs[v].name, "_flags"}, flags(), vecs[v].exp_flags);
      chk({vecs[v].name, "_nreq"}, nreq - reqs0, vecs[v].exp_nreq);
      chk({vecs[v].name, "_early_flag_change"}, partial, 0);
      chk({vecs[v].name, "_addr_unstable"}, addr_bad - bad0, 0);
      @(negedge clock);
      chk({vecs[v].name, "_move_pulse_len"}, move_enable, 0);
      chk({vecs[v].name, "_busy_after"}, busy, 0);
      drop_en = 1'b0;
      repeat (2) @(negedge clock);
    end

    // second frame_tick at T+4: overrun pulse, single commit, snapshot kept
    begin
      int moves, lat;
      for (int i = 0; i < 512; i++) solid_map[i] = 1'b0;
      x_position = 8'd72;
      y_position = 8'd40;
      tick();
      for (int k = 0; k < 10; k++) begin
        if (cyc == t0 + 3) break;
        @(negedge clock);
      end
      x_position = 8'd0;
      frame_tick = 1'b1;
      @(posedge clock);
      #1;
      frame_tick = 1'b0;
      @(negedge clock);
      chk("ovr_pulse", overrun, 1);
      chk("ovr_busy", busy, 1);
      @(negedge clock);
      chk("ovr_pulse_len", overrun, 0);
      moves = 0;
      lat = -1;
      for (int k = 0; k < 30; k++) begin
        if (move_enable) begin
          moves++;
          if (lat < 0) lat = cyc - t0;
        end
        @(negedge clock);
      end
      chk("ovr_commits", moves, 1);
      chk("ovr_latency", lat, 9);
      chk("ovr_flags", flags(), 4'b0000);
    end

    // async reset at T+3: immediate return to reset values, no commit
    begin
      int moves;
      solid_map[201] = 1'b1;
      x_position = 8'd72;
      y_position = 8'd40;
      tick();
      for (int k = 0; k < 10; k++) begin
        if (cyc == t0 + 2) break;
        @(negedge clock);
      end
      resetn = 1'b0;
      #1;
      chk("arst_flags", flags(), 4'b1111);
      chk("arst_req", mem_req, 0);
      chk("arst_busy", busy, 0);
      @(negedge clock);
      resetn = 1'b1;
      moves = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clock);
        if (move_enable) moves++;
      end
      chk("arst_no_move", moves, 0);
      chk("arst_flags_hold", flags(), 4'b1111);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
